// File: rtl/dram_rqst_arbiter_if.sv
// Handshake bundle between the flash-channel requesters, the DRAM request arbiter,
// the DRAM request FIFO and the completion path of the PLB master controller.
interface dram_rqst_arbiter_if #(
    parameter int NUM_RQSTERS               = 4,
    parameter int DRAM_RQST_FIFO_DATA_WIDTH = 45,
    parameter int TAG_FIFO_AWIDTH           = 4
);
    logic [NUM_RQSTERS-1:0]                           i_rqst_valid;
    logic [NUM_RQSTERS*DRAM_RQST_FIFO_DATA_WIDTH-1:0] i_rqst_data;
    logic [NUM_RQSTERS-1:0]                           o_rqst_ack;
    logic [NUM_RQSTERS-1:0]                           o_rqst_done;
    logic [NUM_RQSTERS-1:0]                           o_rqst_err;
    logic [DRAM_RQST_FIFO_DATA_WIDTH-1:0]             o_dram_rqst_fifo_data;
    logic                                             o_dram_rqst_fifo_we;
    logic                                             i_dram_rqst_fifo_full;
    logic                                             i_rqst_complete;
    logic [TAG_FIFO_AWIDTH:0]                         o_outstanding;
    logic                                             o_tag_underflow;

    // The arbiter is the master: it writes the request FIFO and answers requesters.
    modport master (
        input  i_rqst_valid,
        input  i_rqst_data,
        input  i_dram_rqst_fifo_full,
        input  i_rqst_complete,
        output o_rqst_ack,
        output o_rqst_done,
        output o_rqst_err,
        output o_dram_rqst_fifo_data,
        output o_dram_rqst_fifo_we,
        output o_outstanding,
        output o_tag_underflow
    );

    modport slave (
        output i_rqst_valid,
        output i_rqst_data,
        output i_dram_rqst_fifo_full,
        output i_rqst_complete,
        input  o_rqst_ack,
        input  o_rqst_done,
        input  o_rqst_err,
        input  o_dram_rqst_fifo_data,
        input  o_dram_rqst_fifo_we,
        input  o_outstanding,
        input  o_tag_underflow
    );
endinterface

// File: rtl/dram_rqst_arbiter.sv
// Round-robin arbiter sharing the DRAM request FIFO among flash-channel requesters, with an
// in-order tag FIFO routing completions back. Define DRAM_RQST_LEN_CHECK_EN to reject bad lengths.
module dram_rqst_arbiter #(
    parameter int NUM_RQSTERS               = 4,
    parameter int RQSTER_ID_WIDTH           = 2,
    parameter int DRAM_RQST_FIFO_DATA_WIDTH = 45,
    parameter int TAG_FIFO_AWIDTH           = 4
) (
    input  logic                Bus2IP_Clk,
    input  logic                Bus2IP_Resetn,
    dram_rqst_arbiter_if.master rqst_if
);

    localparam int TAG_DEPTH = 2 ** TAG_FIFO_AWIDTH;
    localparam int CNT_W     = TAG_FIFO_AWIDTH + 1;
    localparam int IDX_W     = RQSTER_ID_WIDTH + 1;
    localparam int DW        = DRAM_RQST_FIFO_DATA_WIDTH;

    localparam logic [CNT_W-1:0] TAG_FULL_CNT = CNT_W'(TAG_DEPTH);
    localparam logic [IDX_W-1:0] NUM_RQ_IDX   = IDX_W'(NUM_RQSTERS);

    typedef enum logic {
        ARB  = 1'b0,
        PUSH = 1'b1
    } state_e;

    state_e                     state_q,      state_d;
    logic [RQSTER_ID_WIDTH-1:0] rr_ptr_q,     rr_ptr_d;
    logic [TAG_FIFO_AWIDTH-1:0] tag_wr_ptr_q, tag_wr_ptr_d;
    logic [TAG_FIFO_AWIDTH-1:0] tag_rd_ptr_q, tag_rd_ptr_d;
    logic [CNT_W-1:0]           tag_cnt_q,    tag_cnt_d;
    logic [DW-1:0]              fifo_data_q,  fifo_data_d;
    logic                       fifo_we_q,    fifo_we_d;
    logic [NUM_RQSTERS-1:0]     ack_q,        ack_d;
    logic [NUM_RQSTERS-1:0]     done_q,       done_d;
    logic [NUM_RQSTERS-1:0]     err_q,        err_d;
    logic                       underflow_q,  underflow_d;

    logic [RQSTER_ID_WIDTH-1:0] tag_mem_q [TAG_DEPTH];

    logic [DW-1:0]              rqst_word [NUM_RQSTERS];
    logic                       grant_found;
    logic [RQSTER_ID_WIDTH-1:0] grant_idx;
    logic [RQSTER_ID_WIDTH-1:0] grant_next;
    logic [DW-1:0]              grant_word;
    logic                       can_grant;
    logic                       len_ok;
    logic                       tag_push;
    logic                       tag_pop;
    logic [RQSTER_ID_WIDTH-1:0] tag_head;

    for (genvar k = 0; k < NUM_RQSTERS; k++) begin : g_unpack
        assign rqst_word[k] = rqst_if.i_rqst_data[k*DW +: DW];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_RQSTERS.
    always_comb begin : rr_search
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] nxt;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_RQSTERS; k++) begin
            cand = {1'b0, rr_ptr_q} + IDX_W'(k);
            if (cand >= NUM_RQ_IDX) begin
                cand = cand - NUM_RQ_IDX;
            end
            if (!grant_found && rqst_if.i_rqst_valid[cand[RQSTER_ID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[RQSTER_ID_WIDTH-1:0];
            end
        end
        nxt = {1'b0, grant_idx} + IDX_W'(1);
        if (nxt == NUM_RQ_IDX) begin
            nxt = '0;
        end
        grant_next = nxt[RQSTER_ID_WIDTH-1:0];
    end

    assign grant_word = rqst_word[grant_idx];
    assign can_grant  = grant_found && !rqst_if.i_dram_rqst_fifo_full && (tag_cnt_q < TAG_FULL_CNT);

`ifdef DRAM_RQST_LEN_CHECK_EN
    localparam int LEN_LSB = 1;
    localparam int LEN_MSB = 12;

    logic [LEN_MSB-LEN_LSB:0] grant_len;

    assign grant_len = grant_word[LEN_MSB:LEN_LSB];
    assign len_ok    = (grant_len != '0) && (grant_len[3:0] == 4'h0);
`else
    assign len_ok = 1'b1;
`endif

    // Grant is made only from ARB; the PUSH bubble lets full and requester valid settle.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        fifo_data_d = '0;
        fifo_we_d   = 1'b0;
        ack_d       = '0;
        err_d       = '0;
        tag_push    = 1'b0;
        case (state_q)
            ARB: begin
                if (can_grant) begin
                    rr_ptr_d = grant_next;
                    state_d  = PUSH;
                    if (len_ok) begin
                        fifo_data_d          = grant_word;
                        fifo_we_d            = 1'b1;
                        ack_d[grant_idx]     = 1'b1;
                        tag_push             = 1'b1;
                    end else begin
                        err_d[grant_idx]     = 1'b1;
                    end
                end
            end
            PUSH: begin
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_comb begin
        tag_head     = tag_mem_q[tag_rd_ptr_q];
        tag_pop      = rqst_if.i_rqst_complete && (tag_cnt_q != '0);
        done_d       = '0;
        underflow_d  = underflow_q;
        if (tag_pop) begin
            done_d[tag_head] = 1'b1;
        end
        if (rqst_if.i_rqst_complete && (tag_cnt_q == '0)) begin
            underflow_d = 1'b1;
        end
        tag_wr_ptr_d = tag_wr_ptr_q + TAG_FIFO_AWIDTH'(tag_push);
        tag_rd_ptr_d = tag_rd_ptr_q + TAG_FIFO_AWIDTH'(tag_pop);
        tag_cnt_d    = tag_cnt_q + CNT_W'(tag_push) - CNT_W'(tag_pop);
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q      <= ARB;
            rr_ptr_q     <= '0;
            tag_wr_ptr_q <= '0;
            tag_rd_ptr_q <= '0;
            tag_cnt_q    <= '0;
            fifo_data_q  <= '0;
            fifo_we_q    <= 1'b0;
            ack_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            tag_wr_ptr_q <= tag_wr_ptr_d;
            tag_rd_ptr_q <= tag_rd_ptr_d;
            tag_cnt_q    <= tag_cnt_d;
            fifo_data_q  <= fifo_data_d;
            fifo_we_q    <= fifo_we_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            err_q        <= err_d;
            underflow_q  <= underflow_d;
        end
    end

    // Tag storage needs no reset: occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge Bus2IP_Clk) begin
        if (tag_push) begin
            tag_mem_q[tag_wr_ptr_q] <= grant_idx;
        end
    end

    assign rqst_if.o_dram_rqst_fifo_data = fifo_data_q;
    assign rqst_if.o_dram_rqst_fifo_we   = fifo_we_q;
    assign rqst_if.o_rqst_ack            = ack_q;
    assign rqst_if.o_rqst_done           = done_q;
    assign rqst_if.o_rqst_err            = err_q;
    assign rqst_if.o_outstanding         = tag_cnt_q;
    assign rqst_if.o_tag_underflow       = underflow_q;

endmodule
